// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage HI/LO multiply/divide unit: op codes, FSM states and
// the operand width.
package ex_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per run cycle, with the signed result fix-up on the outputs.
module md_iter_core #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] res_hi_o,
  output logic [Width-1:0] res_lo_o
);

  logic [2*Width-1:0] acc_q;
  logic [Width-1:0]   opnd_q;
  logic [CntW-1:0]    cnt_q;
  logic               div_q, neg_lo_q, neg_hi_q, bzero_q;

  logic               a_neg, b_neg;
  logic [Width-1:0]   a_abs, b_abs;
  logic [Width:0]     mul_sum, div_shift, div_diff;
  logic [2*Width-1:0] mul_next, div_next, prod;
  logic [Width-1:0]   quo, rem;

  always_comb begin
    a_neg = is_signed_i & a_i[Width-1];
    b_neg = is_signed_i & b_i[Width-1];
    a_abs = a_neg ? -a_i : a_i;
    b_abs = b_neg ? -b_i : b_i;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[Width-1:1]};
    div_shift = acc_q[2*Width-1:Width-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[Width] ? {div_shift[Width-1:0], acc_q[Width-2:0], 1'b0}
                                : {div_diff[Width-1:0], acc_q[Width-2:0], 1'b1};
  end

  assign done_o = run_i && (cnt_q == CntW'(Width - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
    end else if (start_i) begin
      acc_q    <= {{Width{1'b0}}, (is_div_i ? a_abs : b_abs)};
      opnd_q   <= is_div_i ? b_abs : a_abs;
      cnt_q    <= '0;
      div_q    <= is_div_i;
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
      bzero_q  <= (b_i == '0);
    end else if (run_i) begin
      acc_q <= div_q ? div_next : mul_next;
      cnt_q <= done_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Divide by zero leaves rem = |dividend|; re-applying the dividend sign restores rs.
  always_comb begin
    prod = neg_lo_q ? -acc_q : acc_q;
    quo  = acc_q[Width-1:0];
    rem  = acc_q[2*Width-1:Width];
    if (div_q) begin
      res_lo_o = bzero_q ? '1 : (neg_lo_q ? -quo : quo);
      res_hi_o = neg_hi_q ? -rem : rem;
    end else begin
      res_lo_o = prod[Width-1:0];
      res_hi_o = prod[2*Width-1:Width];
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: owns HI/LO, sequences iterative MULT/DIV and raises the EX stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, no stall.
module ex_muldiv #(
  parameter int unsigned XLEN  = ex_muldiv_pkg::XLEN,
  parameter int unsigned CNT_W = ex_muldiv_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            flush,
  output logic            stall_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  import ex_muldiv_pkg::*;

  md_state_t       state_q, state_d;
  md_op_t          op_e;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            is_mul, is_div, is_signed, start_iter;
  logic            core_start, core_run, core_done;
  logic [XLEN-1:0] core_hi, core_lo;

  assign op_e      = md_op_t'(op);
  assign is_mul    = (op_e == MD_MULT) || (op_e == MD_MULTU);
  assign is_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  always_comb begin
    fast_a    = {{XLEN{is_signed & rs_data[XLEN-1]}}, rs_data};
    fast_b    = {{XLEN{is_signed & rt_data[XLEN-1]}}, rt_data};
    fast_prod = fast_a * fast_b;
  end

  assign start_iter = op_valid && is_div;
`else
  assign start_iter = op_valid && (is_mul || is_div);
`endif

  md_iter_core #(
    .Width (XLEN),
    .CntW  (CNT_W)
  ) u_core (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (core_start),
    .run_i       (core_run),
    .is_div_i    (is_div),
    .is_signed_i (is_signed),
    .a_i         (rs_data),
    .b_i         (rt_data),
    .done_o      (core_done),
    .res_hi_o    (core_hi),
    .res_lo_o    (core_lo)
  );

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    core_start = 1'b0;
    core_run   = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start_iter) begin
          stall_o    = 1'b1;
          core_start = 1'b1;
          state_d    = StRun;
        end else if (op_valid && op_e == MD_MTHI) begin
          hi_d = rs_data;
        end else if (op_valid && op_e == MD_MTLO) begin
          lo_d = rs_data;
`ifdef MULDIV_FAST_MUL_EN
        end else if (op_valid && is_mul) begin
          hi_d = fast_prod[2*XLEN-1:XLEN];
          lo_d = fast_prod[XLEN-1:0];
`endif
        end
      end
      StRun: begin
        stall_o  = 1'b1;
        core_run = 1'b1;
        if (core_done) state_d = StFix;
      end
      StFix: begin
        stall_o = 1'b1;
        hi_d    = core_hi;
        lo_d    = core_lo;
        state_d = StDone;
      end
      // The held op_valid here belongs to the retiring instruction.
      StDone: state_d = StIdle;
    endcase
    if (flush) begin
      state_d    = StIdle;
      stall_o    = 1'b0;
      core_start = 1'b0;
      core_run   = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle HI/LO unit in the EX stage.
- Executes MULT/MULTU/DIV/DIVU iteratively and handles MTHI/MTLO writes.
- Owns the HI/LO architectural registers.
- Its stall_o is the EX-stage stall request that the stall controller turns into IF/ID freezes. It therefore sits directly upstream of stall control.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  the EX instruction is a HI/LO-class op. Held stable by the pipeline while stall_o=1.
- op  in  3  md_op_t code: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO.
- rs_data  in  XLEN  source A (multiplicand/dividend, or the MTHI/MTLO value).
- rt_data  in  XLEN  source B (multiplier/divisor).
- flush  in  1  EX instruction is squashed (exception/redirect).
- stall_o  out  1  request to freeze the pipeline; drives the stall controller's EX stall input.
- hi_o  out  XLEN  current HI.
- lo_o  out  XLEN  current LO.

Behaviour:
- Reset: state=IDLE, hi_o=0, lo_o=0, counter=0, stall_o=0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - op_valid with MULT/MULTU/DIV/DIVU: stall_o=1 combinationally in the same cycle. Latch |rs|, |rt| (raw values for unsigned ops) and the result signs; counter=0; go to RUN.
  - MTHI/MTLO: write the register at the clock edge; no stall. hi_o/lo_o show the new value next cycle.
  - MFHI/MFLO: no stall; the EX mux reads hi_o/lo_o directly.
- RUN:
  - stall_o=1; exactly XLEN cycles.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: radix-2 restoring division.
  - Counter wraps to 0 on leaving RUN; go to FIX.
- FIX:
  - stall_o=1.
  - Signed multiply: negate the 64-bit product if operand signs differ.
  - Signed divide: quotient negated if signs differ; remainder takes the sign of the dividend.
  - HI/LO written at the end of FIX (HI=product[63:32] or remainder; LO=product[31:0] or quotient). Go to DONE.
- DONE:
  - stall_o=0 for one cycle so the instruction retires. op_valid in this cycle is the same instruction and is ignored.
  - Return to IDLE.
- Latency: 34 stall cycles (accept + 32 RUN + FIX); the instruction advances in the 35th cycle. An op arriving the cycle after DONE starts normally.
- Any op with op_valid while state≠IDLE: stall_o=1. This covers MFHI/MFLO following a busy op.
- Divide by zero: no trap, same latency. Result is LO=32'hFFFF_FFFF, HI=rs_data, irrespective of signedness.
- Signed overflow case 0x8000_0000 / -1: LO=0x8000_0000, HI=0.
- flush:
  - Beats everything except rst.
  - Any state goes to IDLE next cycle; HI/LO unchanged.
  - stall_o is forced to 0 in the flush cycle.
  - A start and a flush in the same cycle: the start is dropped.
- rst mid-operation: immediate return to reset values at the next edge.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU compute a single-cycle combinational 64-bit product. HI/LO are written at the accept edge, stall_o stays 0 and the FSM is not entered. Divide is unchanged.
- Undefined: multiply uses the iterative 34-stall-cycle path described above.

Decomposition:
- Shared package (common.vh / core package) holds:
  - md_op_t enum and its codes.
  - FSM state enum md_state_t.
  - XLEN constant.
- One natural sub-module: md_iter_core. It implements the shift-add/restoring datapath, the counter and the sign fix, with start/done ports. ex_muldiv keeps the FSM, the HI/LO registers and the flush/stall logic.

Test Plan:
- MULT rs=-3 (0xFFFF_FFFD), rt=7 -> stall_o high 34 cycles; then HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; stall_o=0 in DONE.
- DIVU rs=100, rt=7 -> LO=14, HI=2 after 34 stalls. DIV rs=-100, rt=7 -> LO=-14 (0xFFFF_FFF2), HI=-2 (0xFFFF_FFFE).
- DIV rs=0x1234, rt=0 -> LO=0xFFFF_FFFF, HI=0x1234, 34 stalls. DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- MTHI 0xDEAD_BEEF in IDLE -> no stall, hi_o=0xDEAD_BEEF next cycle. MFLO issued while DIVU busy -> stall_o stays 1 until DONE.
- DIVU started, flush asserted at RUN cycle 10 -> stall_o=0 that cycle, IDLE next cycle, HI/LO keep their prior values. rst at RUN cycle 5 -> HI=LO=0, IDLE.
- With MULDIV_FAST_MUL_EN: MULTU 0xFFFF_FFFF*2 -> no stall, HI=1, LO=0xFFFF_FFFE next cycle.
